// File: rtl/comparator_seq.sv
// Sequential magnitude comparator: examines one DIGIT-wide slice per cycle,
// most-significant digit first, and stops at the first differing digit.
module comparator_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4,
  parameter int unsigned CW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             less,
  output logic             equal,
  output logic             greater,
  output logic [CW-1:0]    cycles
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NDIG - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_a, r_b, w_a_d, w_b_d;
  logic [IW-1:0]    r_idx, w_idx_d;
  logic             r_less, r_equal, r_greater;
  logic             w_less_d, w_equal_d, w_greater_d;
  logic [CW-1:0]    r_cycles, w_cycles_d;
  logic [WIDTH-1:0] w_sign_flip;
  logic [DIGIT-1:0] w_dig_a, w_dig_b;

  // Inverting the operand sign bits turns a two's-complement compare into an
  // unsigned one, so the digit datapath never needs to know the mode.
  assign w_sign_flip = WIDTH'(signed_mode) << (WIDTH - 1);

  // Operands shift left as digits match, so the digit under test is always on top.
  assign w_dig_a = r_a[WIDTH-1 -: DIGIT];
  assign w_dig_b = r_b[WIDTH-1 -: DIGIT];

  // Next-state and result update logic.
  always_comb begin
    w_state_d   = r_state;
    w_a_d       = r_a;
    w_b_d       = r_b;
    w_idx_d     = r_idx;
    w_less_d    = r_less;
    w_equal_d   = r_equal;
    w_greater_d = r_greater;
    w_cycles_d  = r_cycles;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_a_d       = a ^ w_sign_flip;
          w_b_d       = b ^ w_sign_flip;
          w_idx_d     = '0;
          w_less_d    = 1'b0;
          w_equal_d   = 1'b0;
          w_greater_d = 1'b0;
          w_cycles_d  = '0;
          w_state_d   = StRun;
        end
      end
      StRun: begin
        if (w_dig_a != w_dig_b) begin
          w_less_d    = (w_dig_a < w_dig_b);
          w_greater_d = (w_dig_a > w_dig_b);
          w_cycles_d  = CW'(r_idx) + CW'(1);
          w_state_d   = StDone;
        end else if (r_idx == LastIdx) begin
          w_equal_d  = 1'b1;
          w_cycles_d = CW'(NDIG);
          w_state_d  = StDone;
        end else begin
          w_idx_d = r_idx + IW'(1);
          w_a_d   = r_a << DIGIT;
          w_b_d   = r_b << DIGIT;
        end
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_less    <= 1'b0;
      r_equal   <= 1'b0;
      r_greater <= 1'b0;
      r_cycles  <= '0;
    end else begin
      r_state   <= w_state_d;
      r_a       <= w_a_d;
      r_b       <= w_b_d;
      r_idx     <= w_idx_d;
      r_less    <= w_less_d;
      r_equal   <= w_equal_d;
      r_greater <= w_greater_d;
      r_cycles  <= w_cycles_d;
    end
  end

  assign busy    = (r_state != StIdle);
  assign done    = (r_state == StDone);
  assign less    = r_less;
  assign equal   = r_equal;
  assign greater = r_greater;
  assign cycles  = r_cycles;

endmodule

// File: doc/comparator_seq.md
COMPARATOR_SEQ -- requirements
Module: comparator_seq

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, giving the bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT, and NDIG = WIDTH/DIGIT.
REQ-003 The block SHALL have parameter CW, default 5, giving the width of the cycles output; CW SHALL satisfy 2^CW > NDIG.

Interface
REQ-004 clk  input  1  Single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  Synchronous reset, active-low, sampled on the clk rising edge.
REQ-006 start  input  1  Request to start a compare; accepted only in IDLE.
REQ-007 a  input  WIDTH  Operand A; sampled at acceptance.
REQ-008 b  input  WIDTH  Operand B; sampled at acceptance.
REQ-009 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled at acceptance.
REQ-010 busy  output  1  High while in RUN or DONE.
REQ-011 done  output  1  One-cycle pulse marking valid results.
REQ-012 less  output  1  A < B.
REQ-013 equal  output  1  A == B.
REQ-014 greater  output  1  A > B.
REQ-015 cycles  output  CW  Number of digits examined for the last result (1..NDIG).

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 In IDLE with start=1, the edge SHALL capture a, b and signed_mode into internal registers, set digit index 0 (the MSB digit), clear less/equal/greater/cycles to 0, and go to RUN.
REQ-018 In RUN, each cycle SHALL compare one DIGIT-wide slice of the captured operands, MSB digit first, advancing one digit per cycle.
REQ-019 In signed mode, the MSB digit SHALL be compared with the top bit of each operand inverted (offset-binary); all other digits SHALL be compared unsigned.
REQ-020 If the current digits differ, the edge SHALL register exactly one of less/greater, set cycles = index+1, and go to DONE (early termination).
REQ-021 If the current digits are equal and index = NDIG-1, the edge SHALL set equal=1 and cycles=NDIG, and go to DONE.
REQ-022 If the current digits are equal and index < NDIG-1, the edge SHALL increment the index and remain in RUN.
REQ-023 Latency: with start accepted at edge E0, done SHALL go high at edge E_k, where k = cycles, and SHALL be high for exactly one cycle.
REQ-024 DONE SHALL last exactly one cycle, and its next state SHALL be IDLE unconditionally.
REQ-025 less, equal, greater and cycles SHALL hold their values after DONE until the next accepted start; at most one of less/equal/greater SHALL be 1.
REQ-026 start in RUN or DONE SHALL be ignored, with no effect on the captured operands or the results.
REQ-027 Changes on a, b or signed_mode after acceptance SHALL NOT affect the compare in progress.
REQ-028 busy SHALL be low in IDLE and high in RUN and DONE; the minimum start-to-start spacing SHALL therefore be k+2 cycles.

Reset
REQ-029 With rst_n=0 at a rising edge, the state SHALL become IDLE, and busy, done, less, equal, greater and cycles SHALL all be 0, regardless of start.
REQ-030 A reset in RUN or DONE SHALL abort the compare, discard partial results, and produce no done pulse.
REQ-031 The first start SHALL be accepted at the first edge with rst_n=1 and the state in IDLE.

Verification (WIDTH=16, DIGIT=4)
REQ-032 Equal operands: a=0x1234, b=0x1234, unsigned -> equal=1, cycles=4, done high 4 cycles after acceptance.
REQ-033 Sign handling: a=0x8000, b=0x7FFF with signed_mode=0 -> greater=1, cycles=1; the same operands with signed_mode=1 -> less=1, cycles=1.
REQ-034 Early termination: a=0x12A0, b=0x12B0 -> less=1, cycles=3, done at E3; a=0xFFFE, b=0xFFFF in signed mode -> less=1, cycles=4.
REQ-035 Start while busy: start=1 held continuously with new operands a=0x0001, b=0x0000 applied during RUN -> first result unaffected; second compare accepted only in the IDLE cycle after DONE, giving greater=1.
REQ-036 Reset mid-operation: rst_n=0 for one cycle two cycles after accepting a=0x1234, b=0x1234 -> all outputs 0, no done pulse; a following start completes normally.
